// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with signs fixed up on the final iteration.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Operand conditioning at the start edge
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;

  assign a_sgn    = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                    && a[WIDTH-1];
  assign b_sgn    = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && b[WIDTH-1];
  assign a_mag    = a_sgn ? -a : a;
  assign b_mag    = b_sgn ? -b : b;
  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);

  // One iteration: hi/lo are {acc, multiplier} for multiply, {remainder, dividend/quotient} for divide
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step, lo_step;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, bmag_q};

  always_comb begin
    if (op_q[2]) begin
      hi_step = div_ge ? WIDTH'(div_shift - {1'b0, bmag_q}) : div_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the values produced by the last iteration
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin;

  assign prod   = {hi_step, lo_step};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_step : lo_step;
  assign rem_s  = neg_q ? -hi_step : hi_step;

  always_comb begin
    case (op_q)
      OP_MUL:                    fin = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011:    fin = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:            fin = quo_s;
      default:                   fin = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bmag_d   = bmag_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          if (div_zero) begin
            result_d = op[1] ? a : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            // remainder sign follows the dividend only
            neg_d   = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
            hi_d    = '0;
            lo_d    = op[2] ? a_mag : b_mag;
            bmag_d  = op[2] ? b_mag : a_mag;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          result_d = fin;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bmag_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bmag_q   <= bmag_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results, a monitor pops
// and compares on every done pulse; the issuing task also checks busy length and latency.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] sb[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done actual=%h required=no_pulse", result);
      end else begin
        check("result", result, sb.pop_front());
      end
    end
  end

  // Issue one op; glitch_at>0 pulses start with junk operands during RUN cycle glitch_at
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int exp_busy, input int glitch_at);
    int n, nb;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    n = 0; nb = 0;
    forever begin
      @(negedge clk);
      if (start) start = 1'b0;
      n++;
      if (busy) nb++;
      if (done || n >= 40) break;
      if (n == glitch_at) begin
        start = 1'b1; op = 3'b000; a = 32'h0000_0003; b = 32'h0000_0005;
      end
    end
    check("busy_cycles", 32'(nb), 32'(exp_busy));
    check("done_latency", 32'(n), 32'(exp_busy + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0);
    run_op(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32, 0);
    run_op(3'b000, 32'd5,        32'd0,         32'd0,         32, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 0);
    run_op(3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0);
    run_op(3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         32, 0);
    run_op(3'b101, 32'd100,      32'd7,         32'd14,        32, 0);
    run_op(3'b111, 32'd100,      32'd7,         32'd2,         32, 0);
    run_op(3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, 0,  0);
    run_op(3'b111, 32'd5,        32'd0,         32'd5,         0,  0);
    run_op(3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 0,  0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0,  0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0,  0);

    // start during RUN must be ignored; the following start in IDLE is accepted
    run_op(3'b101, 32'd1000,     32'd9,         32'd111,       32, 10);
    run_op(3'b000, 32'd6,        32'd7,         32'd42,        32, 0);

    // asynchronous reset mid-run aborts without a done pulse
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_rst", 32'(nd), 32'd0);
    run_op(3'b111, 32'd100,      32'd7,         32'd2,         32, 0);

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
